read_data_dispatcher: RTL
=========================

# read_data_dispatcher

Return-path counterpart of the write arbiter's channel selection stage. Accepts one read-data word per cycle from the SRAM read path, tagged with its 4-bit destination port index, and steers it into a small per-port buffer. Each of the `num_of_ports` client ports then drains its own buffer through an independent valid/ready handshake, so a stalled client never blocks delivery to the others.

## Interface
- `num_of_ports`, 16, number of client ports; 1..16.
- `arbiter_data_width`, 256, data word width in bits.
- `port_fifo_depth`, 2, entries per port buffer; power of two, ≥2.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low; deassertion synchronous to `clk` outside this block.
- `in_valid`  in  1  upstream word present.
- `in_ready`  out  1  block can take the word on `in_port`.
- `in_port`  in  4  destination port index.
- `in_data`  in  `arbiter_data_width`  read-data word.
- `out_data`  out  `arbiter_data_width*num_of_ports`  packed; port i at bits [(i+1)*W-1 : i*W].
- `out_valid`  out  `num_of_ports`  bit i: port i head word valid.
- `out_ready`  in  `num_of_ports`  bit i: port i consumes head.
- `bad_port`  out  1  one-cycle pulse: a word addressed to a nonexistent port was dropped.
- `idle`  out  1  all port buffers empty.

## Operation
- Push: `in_valid && in_ready` at a rising edge writes `in_data` into buffer `in_port`.
- `in_ready` is combinational from `in_port` and buffer state only: `in_ready = !full[in_port]` for `in_port < num_of_ports`; 1 for `in_port >= num_of_ports`. No path from `in_valid` or `out_ready`.
- Invalid index (`in_port >= num_of_ports`): word accepted and discarded; `bad_port` = 1 for the following cycle; no buffer changes.
- Pop: port i pops when `out_valid[i] && out_ready[i]`; independent per port, all ports may pop in the same cycle.
- `out_valid[i] = !empty[i]`; `out_data` slice i = head entry when valid, all-zero when empty.
- Per-port buffer: FIFO, `port_fifo_depth` entries, read/write pointers of width log2(depth) that wrap modulo depth, occupancy counter 0..depth.
- Full port: `in_ready` = 0 even if the same port pops that cycle; no combinational ready bypass.
- Simultaneous push and pop on one non-full, non-empty port: occupancy unchanged, both pointers advance.
- Push to an empty port while it is being popped cannot occur (`out_valid` = 0 when empty).
- Upstream may change `in_port`/`in_data` while `in_valid` is low; while `in_valid` is high and `in_ready` low it must hold them stable.
- `idle = &empty`.

## Timing
- Reset (`rst` = 0, asynchronous): all occupancies 0, pointers 0, `out_valid` = 0, `out_data` = 0, `bad_port` = 0, `idle` = 1. `in_ready` follows from empty state. Reset mid-transfer discards all buffered words; no partial handshake survives.
- Latency: word pushed at edge N appears on `out_valid`/`out_data` of its port after edge N (cycle N+1) if the port was empty; otherwise behind earlier words in FIFO order.
- Throughput: one push per cycle sustained to any mix of ports with ready consumers; per-port sustained rate one word per cycle when its consumer holds `out_ready` high.
- `full` freed by a pop at edge N raises `in_ready` for that port in cycle N+1.
- `bad_port` registered: asserted in cycle N+1 for a discard at edge N.

## Structure
- Shared package: `PORT_IDX_W` = 4, default `num_of_ports`/`arbiter_data_width` constants, occupancy-width function (clog2(depth)+1).
- Sub-module `dispatch_port_fifo`: one buffer (push, pop, data in, head out, empty, full), instantiated `num_of_ports` times via generate; top holds push decode, `in_ready` mux, `bad_port`, packing.

## Test plan
- Reset then single word 0xA5…A5 to port 3, `out_ready[3]`=1 -> `out_valid[3]` high exactly one cycle after push, data matches, other `out_valid` bits 0, `idle` returns to 1.
- Three words to port 7 with `out_ready[7]`=0, depth 2 -> first two accepted, third sees `in_ready`=0; raise `out_ready[7]` -> words pop in order, third accepted the cycle after first pop.
- Back-to-back pushes to ports 0,1,…,15 with all `out_ready`=1 -> 16 accepts in 16 cycles, each port delivers its word once, no stalls.
- Port 2 full, simultaneous push to port 2 and pop of port 2 -> push refused; push to port 5 same cycle accepted.
- `num_of_ports`=8, push to index 12 -> `in_ready`=1, `bad_port` pulses one cycle, all `out_valid` stay 0.
- Fill ports 1 and 4, assert `rst`=0 asynchronously mid-cycle -> all `out_valid`, `out_data`, `bad_port` clear immediately; after release, pointer wrap verified with 5 sequential words through port 4.

Source files
------------

// File: rtl/read_data_dispatcher_pkg.sv
// Shared constants and helpers for the read-data return path.
package read_data_dispatcher_pkg;

  localparam int PORT_IDX_W             = 4;
  localparam int NUM_OF_PORTS_DEF       = 16;
  localparam int ARBITER_DATA_WIDTH_DEF = 256;
  localparam int PORT_FIFO_DEPTH_DEF    = 2;

  typedef logic [PORT_IDX_W-1:0] port_idx_t;

  // Occupancy must represent 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/read_data_dispatcher_port_fifo.sv
// One per-port return buffer: small FIFO with a combinational head that reads zero when empty.
module dispatch_port_fifo
  import read_data_dispatcher_pkg::*;
#(
  parameter int DEPTH = PORT_FIFO_DEPTH_DEF,
  parameter int WIDTH = ARBITER_DATA_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = occ_width(DEPTH);
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             do_push, do_pop;

  assign empty_o = (occ_q == '0);
  assign full_o  = (occ_q == DEPTH_OCC);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Depth is a power of two, so plain pointer increments wrap modulo depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      occ_d = occ_q + 1'b1;
    else if (!do_push && do_pop) occ_d = occ_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/read_data_dispatcher.sv
// Steers tagged read-data words into per-port FIFOs, each drained by its own valid/ready client.
module read_data_dispatcher
  import read_data_dispatcher_pkg::*;
#(
  parameter int num_of_ports       = NUM_OF_PORTS_DEF,
  parameter int arbiter_data_width = ARBITER_DATA_WIDTH_DEF,
  parameter int port_fifo_depth    = PORT_FIFO_DEPTH_DEF
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [PORT_IDX_W-1:0]                    in_port,
  input  logic [arbiter_data_width-1:0]            in_data,
  output logic [arbiter_data_width*num_of_ports-1:0] out_data,
  output logic [num_of_ports-1:0]                  out_valid,
  input  logic [num_of_ports-1:0]                  out_ready,
  output logic                                     bad_port,
  output logic                                     idle
);

  localparam int IDX_SPAN = 1 << PORT_IDX_W;
  localparam logic [PORT_IDX_W:0] NUM_PORTS_EXT = (PORT_IDX_W + 1)'(num_of_ports);

  logic [num_of_ports-1:0] push, pop, empty, full;
  logic [IDX_SPAN-1:0]     full_ext;
  logic                    port_ok;
  logic                    bad_port_q, bad_port_d;

  // Nonexistent ports read as never-full so the word is swallowed and reported.
  generate
    for (genvar gi = 0; gi < IDX_SPAN; gi++) begin : g_full_ext
      if (gi < num_of_ports) begin : g_real
        assign full_ext[gi] = full[gi];
      end else begin : g_phantom
        assign full_ext[gi] = 1'b0;
      end
    end
  endgenerate

  assign port_ok  = ({1'b0, in_port} < NUM_PORTS_EXT);
  assign in_ready = port_ok ? !full_ext[in_port] : 1'b1;

  generate
    for (genvar gi = 0; gi < num_of_ports; gi++) begin : g_port
      assign push[gi]      = in_valid && in_ready && (in_port == port_idx_t'(gi));
      assign pop[gi]       = out_valid[gi] && out_ready[gi];
      assign out_valid[gi] = !empty[gi];

      dispatch_port_fifo #(
        .DEPTH (port_fifo_depth),
        .WIDTH (arbiter_data_width)
      ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push[gi]),
        .pop_i   (pop[gi]),
        .data_i  (in_data),
        .head_o  (out_data[gi*arbiter_data_width +: arbiter_data_width]),
        .empty_o (empty[gi]),
        .full_o  (full[gi])
      );
    end
  endgenerate

  assign bad_port_d = in_valid && !port_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bad_port_q <= 1'b0;
    else      bad_port_q <= bad_port_d;
  end

  assign bad_port = bad_port_q;
  assign idle     = &empty;

endmodule
